bcd_to_ascii_tx: RTL and testbench

BCD_TO_ASCII_TX -- requirements
Module: bcd_to_ascii_tx

---
 rtl/bcd_to_ascii_tx_if.sv | 17 +
 rtl/bcd_to_ascii_tx.sv | 97 +++++++++
 tb/tb_bcd_to_ascii_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_ascii_tx_if.sv
// Handshake bundle for the BCD-to-ASCII serializer: result capture side and byte stream side.
interface bcd_to_ascii_tx_if #(parameter int DIGITS = 10);
  logic                  done_i;
  logic                  err_i;
  logic [DIGITS*4-1:0]   bcd_i;
  logic [DIGITS-1:0]     digit_en_i;
  logic [7:0]            ascii_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  busy_o;
  logic                  overrun_o;

  modport master (output done_i, err_i, bcd_i, digit_en_i, ready_i,
                  input  ascii_o, valid_o, busy_o, overrun_o);
  modport slave  (input  done_i, err_i, bcd_i, digit_en_i, ready_i,
                  output ascii_o, valid_o, busy_o, overrun_o);
endinterface

// File: rtl/bcd_to_ascii_tx.sv
// Serializes a captured BCD conversion result (or "ERR") as ASCII bytes over a
// valid/ready stream, optionally terminated by CR LF.
module bcd_to_ascii_tx #(
  parameter int DIGITS    = 10,
  parameter bit EMIT_CRLF = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  bcd_to_ascii_tx_if.slave bus
);
  localparam int IW = (DIGITS > 4) ? $clog2(DIGITS) : 2;

  typedef enum logic [2:0] {IDLE, DIG, ERR, CR, LF} state_t;

  state_t                state_q, state_nxt, last_nxt;
  logic [IW-1:0]         idx_q, idx_nxt, top_idx, low_idx;
  logic [DIGITS*4-1:0]   bcd_q;
  logic [DIGITS-1:0]     en_q, cap_mask;
  logic [3:0]            nib;
  logic                  has_low, xfer, overrun_q;

  assign xfer     = bus.valid_o && bus.ready_i;
  assign last_nxt = EMIT_CRLF ? CR : IDLE;

  // An all-zero enable mask still shows the least significant digit.
  assign cap_mask = (bus.digit_en_i == '0) ? DIGITS'(1) : bus.digit_en_i;

  always_comb begin
    top_idx = '0;
    low_idx = '0;
    has_low = 1'b0;
    nib     = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (cap_mask[k]) top_idx = IW'(k);
      // Ascending scan leaves the highest enabled index strictly below idx_q.
      if (en_q[k] && (IW'(k) < idx_q)) begin
        has_low = 1'b1;
        low_idx = IW'(k);
      end
      if (IW'(k) == idx_q) nib = bcd_q[4*k +: 4];
    end
  end

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    case (state_q)
      IDLE: if (bus.done_i) begin
        state_nxt = bus.err_i ? ERR : DIG;
        idx_nxt   = bus.err_i ? '0 : top_idx;
      end
      DIG: if (xfer) begin
        if (has_low) idx_nxt = low_idx;
        else         state_nxt = last_nxt;
      end
      ERR: if (xfer) begin
        if (idx_q == IW'(2)) state_nxt = last_nxt;
        else                 idx_nxt = idx_q + IW'(1);
      end
      CR: if (xfer) state_nxt = LF;
      LF: if (xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      bcd_q     <= '0;
      en_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      idx_q     <= idx_nxt;
      overrun_q <= bus.done_i && (state_q != IDLE);
      if (state_q == IDLE && bus.done_i) begin
        bcd_q <= bus.bcd_i;
        en_q  <= cap_mask;
      end
    end
  end

  always_comb begin
    case (state_q)
      DIG:     bus.ascii_o = (nib > 4'd9) ? 8'h3F : (8'h30 + {4'h0, nib});
      ERR:     bus.ascii_o = (idx_q == '0) ? 8'h45 : 8'h52;
      CR:      bus.ascii_o = 8'h0D;
      LF:      bus.ascii_o = 8'h0A;
      default: bus.ascii_o = 8'h00;
    endcase
  end

  assign bus.valid_o   = (state_q != IDLE);
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.overrun_o = overrun_q;
endmodule

// File: tb/tb_bcd_to_ascii_tx.sv
// Scoreboard bench: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_bcd_to_ascii_tx;
  localparam int DIGITS = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_to_ascii_tx_if #(.DIGITS(DIGITS)) bus ();

  bcd_to_ascii_tx #(.DIGITS(DIGITS), .EMIT_CRLF(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int ov_cnt = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic [DIGITS*4-1:0] bcd, input logic [DIGITS-1:0] en, input logic err);
    logic [DIGITS-1:0] m;
    logic [3:0] d;
    if (err) begin
      exp_q.push_back(8'h45); exp_q.push_back(8'h52); exp_q.push_back(8'h52);
    end else begin
      m = (en == '0) ? DIGITS'(1) : en;
      for (int k = DIGITS - 1; k >= 0; k--) begin
        if (m[k]) begin
          d = bcd[4*k +: 4];
          exp_q.push_back((d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d}));
        end
      end
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic send(input logic [DIGITS*4-1:0] bcd, input logic [DIGITS-1:0] en, input logic err);
    push_expected(bcd, en, err);
    bus.bcd_i = bcd; bus.digit_en_i = en; bus.err_i = err; bus.done_i = 1'b1;
    tick();
    bus.done_i = 1'b0; bus.bcd_i = '0; bus.digit_en_i = '0; bus.err_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((bus.busy_o || exp_q.size() != 0) && n < 300) begin
      bus.ready_i = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    bus.ready_i = 1'b1;
    n_cmp++;
    if (n >= 300) begin
      n_err++;
      $display("FAIL %s_timeout: busy=%0b left=%0d expected idle", name, bus.busy_o, exp_q.size());
    end
  endtask

  // Monitor: pops on every accepted byte and checks held data while stalled.
  initial begin
    logic stall_prev;
    logic [7:0] held, e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", 32'(bus.valid_o), 32'd1);
          chk("stall_hold", 32'(bus.ascii_o), 32'(held));
        end
        if (bus.overrun_o) ov_cnt++;
        if (bus.valid_o && bus.ready_i) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_byte: got %0h expected none", bus.ascii_o);
          end else begin
            n_cmp--;
            e = exp_q.pop_front();
            chk("byte", 32'(bus.ascii_o), 32'(e));
          end
        end
        if (!bus.valid_o) chk("idle_zero", 32'(bus.ascii_o), 32'h0);
        stall_prev = bus.valid_o && !bus.ready_i;
        held = bus.ascii_o;
      end
    end
  end

  initial begin
    bus.done_i = 1'b0; bus.err_i = 1'b0; bus.bcd_i = '0; bus.digit_en_i = '0; bus.ready_i = 1'b0;
    #12;
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_overrun", 32'(bus.overrun_o), 32'd0);
    chk("rst_ascii", 32'(bus.ascii_o), 32'h0);
    tick();
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    tick();

    // Basic 255: one-cycle latency, five back-to-back bytes.
    send(40'h0000000255, 10'b0000000111, 1'b0);
    chk("latency_valid", 32'(bus.valid_o), 32'd1);
    chk("latency_busy", 32'(bus.busy_o), 32'd1);
    repeat (5) tick();
    chk("no_bubble_busy", 32'(bus.busy_o), 32'd0);
    chk("no_bubble_drain", 32'(exp_q.size()), 32'd0);
    tick();

    // Error ignores BCD, zero, empty mask, and out-of-range nibble.
    send(40'h9999999999, 10'h3FF, 1'b1);       wait_idle("err");
    send(40'h0,          10'b1,   1'b0);       wait_idle("zero");
    send(40'h0000000007, 10'b0,   1'b0);       wait_idle("mask0");
    send(40'h000000001A, 10'b11,  1'b0);       wait_idle("nibble");

    // Full width: 12 transfers with ready held high.
    send(40'h4294967295, 10'h3FF, 1'b0);
    repeat (12) tick();
    chk("full_busy", 32'(bus.busy_o), 32'd0);
    chk("full_drain", 32'(exp_q.size()), 32'd0);

    // Backpressure: 5-cycle stall mid-result, then random ready.
    send(40'h4294967295, 10'h3FF, 1'b0);
    repeat (2) tick();
    bus.ready_i = 1'b0;
    repeat (5) tick();
    rdy_mode = 1;
    wait_idle("bp");
    rdy_mode = 0;
    tick();

    // Overrun during DIG and on the final LF transfer.
    ov_cnt = 0;
    send(40'h0000000255, 10'b0000000111, 1'b0);
    bus.done_i = 1'b1; bus.bcd_i = 40'h1111111111; bus.digit_en_i = 10'h3FF;
    tick();
    bus.done_i = 1'b0;
    repeat (3) tick();
    bus.done_i = 1'b1; bus.err_i = 1'b1;
    tick();
    bus.done_i = 1'b0; bus.err_i = 1'b0;
    tick();
    chk("ov_count", 32'(ov_cnt), 32'd2);
    chk("ov_idle", 32'(bus.busy_o), 32'd0);
    chk("ov_drain", 32'(exp_q.size()), 32'd0);

    // Reset during the second digit, then a clean result.
    send(40'h0000000255, 10'b0000000111, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.valid_o), 32'd0);
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    chk("abort_ascii", 32'(bus.ascii_o), 32'h0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(bus.busy_o), 32'd0);
    send(40'h0000000831, 10'b0000000111, 1'b0);
    chk("post_rst_valid", 32'(bus.valid_o), 32'd1);
    wait_idle("post_rst");
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
